riscv_uat_tx: RTL

RISCV_UAT_TX -- requirements
Module: riscv_uat_tx

---
 rtl/riscv_uat_pkg.sv | 26 ++
 rtl/riscv_sync_fifo.sv | 61 ++++++
 rtl/riscv_uat_tx.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_uat_pkg.sv
// Shared definitions for the UART transmitter: register offsets, STATUS/CTRL
// bit positions and the frame FSM state encoding.
package riscv_uat_pkg;

  localparam logic [3:0] UAT_OFS_DATA   = 4'h0;
  localparam logic [3:0] UAT_OFS_STATUS = 4'h4;
  localparam logic [3:0] UAT_OFS_DIV    = 4'h8;
  localparam logic [3:0] UAT_OFS_CTRL   = 4'hC;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;

  localparam int CTRL_IRQEN = 0;
  localparam int CTRL_FLUSH = 1;

  typedef enum logic [1:0] {
    UAT_IDLE,
    UAT_START,
    UAT_DATA,
    UAT_STOP
  } uat_state_e;

endpackage

// File: rtl/riscv_sync_fifo.sv
// Single-clock FIFO with occupancy count and one-cycle flush.
// A push is accepted only when not full, judged before any same-cycle pop.
module riscv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/riscv_uat_tx.sv
// Memory-mapped UART transmitter: register file, TX FIFO and the serial frame
// FSM (start, LSB-first data, stop) with per-frame latched baud divisor.
module riscv_uat_tx
  import riscv_uat_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic [3:0]  wStrb,
  input  logic [31:0] wData,
  output logic [31:0] rData,
  output logic        tx,
  output logic        irq
);

  localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;
  localparam int DIV_RAW = CLK_FREQ / BAUD;
  localparam logic [15:0] DIV_RST = (DIV_RAW < 1)     ? 16'd1 :
                                    (DIV_RAW > 65535) ? 16'hFFFF : 16'(DIV_RAW);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  logic                 w_wr, w_wr_data, w_wr_status, w_wr_div, w_wr_ctrl;
  logic                 w_full, w_empty, w_flush, w_avail;
  logic [FIFO_CW-1:0]   w_count;
  logic [8:0]           w_cnt9;
  logic [DATA_BITS-1:0] w_head;
  logic                 w_bit_end, w_last_stop, w_pop, w_shift, w_busy, w_ovf_set;
  logic [31:0]          w_status;
  logic                 w_unused;

  logic [15:0]          r_div;
  logic                 r_irq_en, r_ovf, r_irq, r_tx;
  uat_state_e           r_state;
  logic [2:0]           r_bit_cnt;
  logic [15:0]          r_clk_cnt;
  logic [15:0]          r_div_lat;
  logic [DATA_BITS-1:0] r_shift;

  assign w_wr        = sel & wStrb[0];
  assign w_wr_data   = w_wr && (addr[3:2] == UAT_OFS_DATA[3:2]);
  assign w_wr_status = w_wr && (addr[3:2] == UAT_OFS_STATUS[3:2]);
  assign w_wr_div    = w_wr && (addr[3:2] == UAT_OFS_DIV[3:2]);
  assign w_wr_ctrl   = w_wr && (addr[3:2] == UAT_OFS_CTRL[3:2]);
  assign w_flush     = w_wr_ctrl && wData[CTRL_FLUSH];
  assign w_ovf_set   = w_wr_data && w_full;

  // A flushed FIFO must not hand its stale head to the FSM in the same cycle.
  assign w_avail     = !w_empty && !w_flush;
  assign w_busy      = (r_state != UAT_IDLE);
  assign w_bit_end   = (r_clk_cnt == 16'd0);
  assign w_last_stop = (r_bit_cnt == LAST_STOP);
  assign w_pop       = w_avail && ((r_state == UAT_IDLE) ||
                       (r_state == UAT_STOP && w_bit_end && w_last_stop));
  assign w_shift     = w_bit_end && (r_state == UAT_START || r_state == UAT_DATA);
  assign w_cnt9      = 9'(w_count);
  assign w_unused    = ^{wStrb[3:1], addr[1:0], wData[31:16], w_cnt9[8]};

  riscv_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_wr_data),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (wData[DATA_BITS-1:0]),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_status                       = '0;
    w_status[STAT_FULL]            = w_full;
    w_status[STAT_EMPTY]           = w_empty;
    w_status[STAT_BUSY]            = w_busy;
    w_status[STAT_OVF]             = r_ovf;
    w_status[STAT_CNT_LSB +: 8]    = w_cnt9[7:0];
  end

  always_comb begin
    rData = '0;
    if (sel) begin
      case (addr[3:2])
        UAT_OFS_STATUS[3:2]: rData = w_status;
        UAT_OFS_DIV[3:2]:    rData = {16'd0, r_div};
        UAT_OFS_CTRL[3:2]:   rData = {31'd0, r_irq_en};
        default:             rData = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div    <= DIV_RST;
      r_irq_en <= 1'b0;
      r_ovf    <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_div)  r_div <= (wData[15:0] == 16'd0) ? 16'd1 : wData[15:0];
      if (w_wr_ctrl) r_irq_en <= wData[CTRL_IRQEN];
      // Set is written last so a same-cycle overflow beats the W1C clear.
      if (w_wr_status && wData[STAT_OVF]) r_ovf <= 1'b0;
      if (w_ovf_set) r_ovf <= 1'b1;
      r_irq <= r_irq_en & w_empty & ~w_busy;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= UAT_IDLE;
      r_tx      <= 1'b1;
      r_bit_cnt <= '0;
      r_clk_cnt <= '0;
    end else begin
      case (r_state)
        UAT_IDLE: begin
          if (w_pop) begin
            r_state   <= UAT_START;
            r_tx      <= 1'b0;
            r_clk_cnt <= r_div - 16'd1;
          end
        end
        UAT_START: begin
          if (w_bit_end) begin
            r_state   <= UAT_DATA;
            r_tx      <= r_shift[0];
            r_bit_cnt <= '0;
            r_clk_cnt <= r_div_lat - 16'd1;
          end else begin
            r_clk_cnt <= r_clk_cnt - 16'd1;
          end
        end
        UAT_DATA: begin
          if (w_bit_end) begin
            r_clk_cnt <= r_div_lat - 16'd1;
            if (r_bit_cnt == LAST_DATA) begin
              r_state   <= UAT_STOP;
              r_tx      <= 1'b1;
              r_bit_cnt <= '0;
            end else begin
              r_tx      <= r_shift[0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt - 16'd1;
          end
        end
        UAT_STOP: begin
          if (w_bit_end && w_last_stop) begin
            if (w_pop) begin
              r_state   <= UAT_START;
              r_tx      <= 1'b0;
              r_clk_cnt <= r_div - 16'd1;
            end else begin
              r_state   <= UAT_IDLE;
            end
          end else if (w_bit_end) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_clk_cnt <= r_div_lat - 16'd1;
          end else begin
            r_clk_cnt <= r_clk_cnt - 16'd1;
          end
        end
        default: r_state <= UAT_IDLE;
      endcase
    end
  end

  // Frame datapath: byte and divisor are captured together at pop time.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_shift   <= w_head;
      r_div_lat <= r_div;
    end else if (w_shift) begin
      r_shift   <= r_shift >> 1;
    end
  end

  assign tx  = r_tx;
  assign irq = r_irq;

endmodule
